// File: rtl/ir_sensor_sampler.sv
// ir_sensor_sampler: MCP3208 SPI sweep (left, right, forward) with per-channel IIR filter
// and a hysteresis comparator on the forward reading.
module ir_sensor_sampler #(
   parameter int unsigned CLK_DIV    = 25,
   parameter logic [2:0]  CH_LEFT    = 3'd0,
   parameter logic [2:0]  CH_RIGHT   = 3'd1,
   parameter logic [2:0]  CH_FWD     = 3'd2,
   parameter int unsigned FILT_SHIFT = 2,
   parameter logic [15:0] FWD_ON_TH  = 16'h8000,
   parameter logic [15:0] FWD_OFF_TH = 16'h7000,
   parameter int unsigned SWEEP_GAP  = 1000
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        sample_en_in,
   input  logic        adc_miso_in,
   output logic        adc_sclk_out,
   output logic        adc_cs_n_out,
   output logic        adc_mosi_out,
   output logic [15:0] left_ir,
   output logic [15:0] right_ir,
   output logic        forward_ir,
   output logic        ir_valid
);
   localparam int unsigned CMAX = SWEEP_GAP > CLK_DIV ? SWEEP_GAP : CLK_DIV;
   localparam int CW = $clog2(CMAX) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE, CSGAP, SWGAP} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               phase_q, phase_d;
   logic [4:0]         bit_idx_q, bit_idx_d;
   logic [1:0]         chan_q, chan_d;
   logic [11:0]        shift_q, shift_d;
   logic [1:0]         sync_q;
   logic [2:0][15:0]   acc_q, acc_d;
   logic [2:0]         prime_q, prime_d;
   logic               fwd_q, fwd_d;
   logic               valid_q, valid_d;
   logic               div_done, gap_done, upd, last_ch;
   logic [2:0]         ch;
   logic [23:0]        cmd;
   logic [15:0]        x, acc_cur, acc_new;
   logic signed [16:0] diff, step;

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = sample_en_in ? SETUP : IDLE;
         SETUP:   state_d = div_done ? SHIFT : SETUP;
         SHIFT:   state_d = div_done && phase_q && bit_idx_q == 5'd23 ? HOLD : SHIFT;
         HOLD:    state_d = div_done ? UPDATE : HOLD;
         UPDATE:  state_d = last_ch ? SWGAP : CSGAP;
         CSGAP:   state_d = div_done ? SETUP : CSGAP;
         SWGAP:   state_d = gap_done ? IDLE : SWGAP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      adc_cs_n_out = state_q inside {IDLE, UPDATE, CSGAP, SWGAP};
      adc_sclk_out = state_q == SHIFT && phase_q;
      adc_mosi_out = state_q inside {SETUP, SHIFT} && cmd[5'd23 - bit_idx_q];
      left_ir      = acc_q[0];
      right_ir     = acc_q[1];
      forward_ir   = fwd_q;
      ir_valid     = valid_q;
   end

   always_comb begin
      div_done  = cnt_q == CW'(CLK_DIV - 1);
      gap_done  = cnt_q == CW'(SWEEP_GAP - 1);
      upd       = state_q == UPDATE;
      last_ch   = chan_q == 2'd2;
      ch        = chan_q == 2'd0 ? CH_LEFT : chan_q == 2'd1 ? CH_RIGHT : CH_FWD;
      cmd       = {5'b0, 2'b11, ch, 14'b0};
      cnt_d     = state_q inside {IDLE, UPDATE} || (state_q == SWGAP ? gap_done : div_done) ? '0 : cnt_q + 1'b1;
      phase_d   = state_q == SHIFT && (div_done ? !phase_q : phase_q);
      bit_idx_d = state_q != SHIFT ? '0 : div_done && phase_q ? bit_idx_q + 1'b1 : bit_idx_q;
      // MISO is captured on the first cycle of each SCLK high phase (the rising edge)
      shift_d   = state_q == SHIFT && phase_q && cnt_q == '0 ? {shift_q[10:0], sync_q[1]} : shift_q;
      chan_d    = state_q == IDLE ? 2'd0 : upd && !last_ch ? chan_q + 2'd1 : chan_q;
      x         = {shift_q, 4'b0};
      acc_cur   = acc_q[chan_q];
      diff      = $signed({1'b0, x}) - $signed({1'b0, acc_cur});
      step      = diff >>> FILT_SHIFT;
      acc_new   = prime_q[chan_q] ? 16'({1'b0, acc_cur} + step) : x;
      acc_d     = acc_q;
      prime_d   = prime_q;
      if (upd) begin
         acc_d[chan_q]   = acc_new;
         prime_d[chan_q] = 1'b1;
      end
      fwd_d     = upd && last_ch ? (acc_new >= FWD_ON_TH ? 1'b1 : acc_new < FWD_OFF_TH ? 1'b0 : fwd_q) : fwd_q;
      valid_d   = upd && last_ch;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         bit_idx_q <= '0;
         chan_q    <= '0;
         shift_q   <= '0;
         sync_q    <= '0;
         acc_q     <= '0;
         prime_q   <= '0;
         fwd_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         bit_idx_q <= bit_idx_d;
         chan_q    <= chan_d;
         shift_q   <= shift_d;
         sync_q    <= {sync_q[0], adc_miso_in};
         acc_q     <= acc_d;
         prime_q   <= prime_d;
         fwd_q     <= fwd_d;
         valid_q   <= valid_d;
      end
   end
endmodule

// File: tb/tb_ir_sensor_sampler.sv
// tb_ir_sensor_sampler: MCP3208 responder plus a behavioural sweep/filter/hysteresis model
// compared against the DUT on every falling clock edge.
module tb_ir_sensor_sampler;
   localparam int CD = 3, GAP = 20, FS = 2;

   logic        clk_in = 1'b0, reset_n_in = 1'b0, sample_en_in = 1'b0, adc_miso_in;
   logic        adc_sclk_out, adc_cs_n_out, adc_mosi_out, forward_ir, ir_valid;
   logic [15:0] left_ir, right_ir;

   ir_sensor_sampler #(.CLK_DIV(CD), .FILT_SHIFT(FS), .SWEEP_GAP(GAP)) dut (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .sample_en_in(sample_en_in),
      .adc_miso_in(adc_miso_in), .adc_sclk_out(adc_sclk_out), .adc_cs_n_out(adc_cs_n_out),
      .adc_mosi_out(adc_mosi_out), .left_ir(left_ir), .right_ir(right_ir),
      .forward_ir(forward_ir), .ir_valid(ir_valid));

   always #5 clk_in = ~clk_in;

   int          total = 0, bad = 0;
   logic [11:0] samp [8];
   logic [11:0] fs = '0, junk = '0, pend_x = '0;
   logic [23:0] cmdv = '0;
   int          rcnt = 0, lowcnt = 0, pend_i = 0, exp_ord = 0;
   int          m_acc [3];
   bit          m_prime [3];
   bit          m_fwd = 0, pend = 0, sclk_prev = 0, cs_prev = 1;

   // bit k of the 24-bit frame: 12 don't-care bits, then the sample MSB first
   assign adc_miso_in = rcnt < 12 ? junk[11 - rcnt] : rcnt < 24 ? fs[23 - rcnt] : 1'b0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk_in) begin
      int x;
      bit ev;
      if (!reset_n_in) begin
         for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_prime[i] = 0; end
         m_fwd = 0; pend = 0; rcnt = 0; lowcnt = 0; exp_ord = 0; sclk_prev = 0; cs_prev = 1;
         chk("rst_cs_n", adc_cs_n_out, 1);
         chk("rst_outs", {adc_sclk_out, adc_mosi_out, forward_ir, ir_valid, left_ir, right_ir}, 0);
      end else begin
         ev = 0;
         if (pend) begin
            x = int'(pend_x) << 4;
            m_acc[pend_i] = m_prime[pend_i] ? m_acc[pend_i] + ((x - m_acc[pend_i]) >>> FS) : x;
            m_prime[pend_i] = 1;
            if (pend_i == 2) begin
               m_fwd = m_acc[2] >= 'h8000 ? 1 : m_acc[2] < 'h7000 ? 0 : m_fwd;
               ev = 1;
            end
            pend = 0;
         end
         chk("left", left_ir, m_acc[0]);
         chk("right", right_ir, m_acc[1]);
         chk("fwd", forward_ir, m_fwd);
         chk("valid", ir_valid, ev);
         if (!adc_cs_n_out) begin
            lowcnt++;
            if (adc_sclk_out && !sclk_prev && rcnt < 24) begin
               cmdv[23 - rcnt] = adc_mosi_out;
               rcnt++;
               if (rcnt == 10) fs = samp[cmdv[16:14]];
            end
         end else begin
            chk("sclk_idle", adc_sclk_out, 0);
            if (!cs_prev) begin
               chk("nrise", rcnt, 24);
               chk("cs_low", lowcnt, 50 * CD);
               chk("cmd", cmdv, {5'b0, 2'b11, 3'(exp_ord), 14'b0});
               pend = 1; pend_i = exp_ord; pend_x = fs;
               exp_ord = (exp_ord + 1) % 3;
            end
            rcnt = 0; lowcnt = 0; junk = 12'($urandom);
         end
         sclk_prev = adc_sclk_out;
         cs_prev = adc_cs_n_out;
      end
   end

   task automatic wait_valid(input string n);
      int i = 0;
      do begin @(negedge clk_in); i++; end while (!ir_valid && i < 3000);
      chk({n, "_timeout"}, ir_valid, 1);
   endtask

   task automatic do_reset();
      @(posedge clk_in); #2 reset_n_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #2 reset_n_in = 1'b1;
   endtask

   initial begin
      logic [15:0] lexp [3];
      logic        fexp [4];
      int          cnt;
      lexp = '{16'h1000, 16'h1C00, 16'h2500};
      fexp = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) samp[i] = '0;
      repeat (3) @(negedge clk_in);
      chk("reset_cs", adc_cs_n_out, 1);
      chk("reset_left", left_ir, 0);
      #2 reset_n_in = 1'b1;

      samp[0] = 12'h123; samp[1] = 12'hABC; samp[2] = 12'h900;
      sample_en_in = 1'b1;
      wait_valid("t1");
      chk("t1_left", left_ir, 16'h1230);
      chk("t1_right", right_ir, 16'hABC0);
      chk("t1_fwd", forward_ir, 1);

      samp[2] = 12'h600;
      for (int k = 0; k < 4; k++) begin
         wait_valid("hyst");
         chk("hyst_fwd", forward_ir, fexp[k]);
      end

      do_reset();
      samp[0] = 12'h000;
      wait_valid("t3");
      chk("t3_left0", left_ir, 16'h0000);
      samp[0] = 12'h400;
      for (int k = 0; k < 3; k++) begin
         wait_valid("t3");
         chk("t3_left", left_ir, lexp[k]);
      end

      cnt = 0;
      while (!adc_sclk_out && cnt < 2000) begin @(posedge clk_in); #2; cnt++; end
      chk("t5_in_shift", adc_sclk_out, 1);
      reset_n_in = 1'b0;
      #1;
      chk("t5_cs", adc_cs_n_out, 1);
      chk("t5_outs", {adc_sclk_out, left_ir, right_ir, forward_ir, ir_valid}, 0);
      repeat (2) @(posedge clk_in);
      samp[0] = 12'h5A5;
      #2 reset_n_in = 1'b1;
      wait_valid("t5");
      chk("t5_prime", left_ir, 16'h5A50);

      cnt = 0;
      while (adc_cs_n_out && cnt < 2000) begin @(negedge clk_in); cnt++; end
      chk("t6_in_frame", adc_cs_n_out, 0);
      sample_en_in = 1'b0;
      wait_valid("t6");
      cnt = 0;
      repeat (300) begin @(negedge clk_in); cnt += adc_cs_n_out ? 0 : 1; end
      chk("t6_stopped", cnt, 0);
      sample_en_in = 1'b1;
      wait_valid("t6_resume");

      for (int k = 0; k < 40; k++) begin
         samp[0] = 12'($urandom);
         samp[1] = 12'($urandom);
         samp[2] = $urandom_range(0, 2) != 0 ? 12'($urandom_range('h6A0, 'h860)) : 12'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            sample_en_in = 1'b0;
            repeat ($urandom_range(1, 600)) @(posedge clk_in);
            #2 sample_en_in = 1'b1;
         end
         wait_valid("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
